// File: rtl/epochtv1_pkg.sv
// Shared types and constants for the Epoch TV-1 sprite line-buffer fill engine.
package epochtv1_pkg;

    // Packed OAM attribute word as read from object attribute memory.
    typedef struct packed {
        logic       split;
        logic [6:0] pat;
        logic [6:0] x;
        logic       link_x;
        logic [3:0] start_line;
        logic [3:0] color;
        logic [6:0] y;
        logic       link_y;
    } s_objattr;

    localparam int OAM_COUNT = 128;
    localparam int OLB_SIZE  = 256;
    localparam int SPR_H     = 16;
    localparam int OLB_W     = 5;

    // Pixel bit for column j of a 16-pixel sprite row; the two pattern words
    // are interleaved by half-row (sy[0]) and half-column (j[2]).
    function automatic logic pix_sel(input logic [15:0] w0, input logic [15:0] w1,
                                     input logic [3:0] j, input logic sy0);
        logic [15:0] w;
        logic [3:0]  k;
        w = j[3] ? w1 : w0;
        k = {~j[2], sy0, j[1:0]};
        return w[4'd15 - k];
    endfunction

endpackage

// File: rtl/epochtv1_olb_fill_if.sv
// Request, OAM, VRAM and OLB-write signals of the OLB fill engine.
interface epochtv1_olb_fill_if;
    import epochtv1_pkg::*;

    logic             START;
    logic [8:0]       ROW;
    logic             BUSY;
    logic             DONE;
    logic [6:0]       OAM_A;
    logic [31:0]      OAM_D;
    logic [10:0]      VA;
    logic [15:0]      VD;
    logic [7:0]       OLB_A;
    logic [OLB_W-1:0] OLB_D;
    logic             OLB_WE;

    // Requester / memory side.
    modport master (
        output START, ROW, OAM_D, VD,
        input  BUSY, DONE, OAM_A, VA, OLB_A, OLB_D, OLB_WE
    );

    // Fill engine side.
    modport slave (
        input  START, ROW, OAM_D, VD,
        output BUSY, DONE, OAM_A, VA, OLB_A, OLB_D, OLB_WE
    );
endinterface

// File: rtl/epochtv1_olb_fill.sv
// OLB fill engine: clears the object line buffer, scans all OAM entries for the
// latched row and draws opaque pixels of every intersecting sprite in scan order.
module epochtv1_olb_fill
    import epochtv1_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    epochtv1_olb_fill_if.slave  bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] OREAD  = 3'd2;
    localparam logic [2:0] OEVAL  = 3'd3;
    localparam logic [2:0] FETCH0 = 3'd4;
    localparam logic [2:0] FETCH1 = 3'd5;
    localparam logic [2:0] DRAW   = 3'd6;
    localparam logic [2:0] FIN    = 3'd7;

    logic [2:0]       state;
    logic [6:0]       idx;
    logic [3:0]       j_q;
    logic [8:0]       row_q;
    logic [3:0]       sy_q;
    logic [6:0]       pat_q;
    logic [6:0]       x_q;
    logic [3:0]       color_q;
    logic [15:0]      w0_q;
    logic [15:0]      w1_q;

    logic             busy_q;
    logic             done_q;
    logic [6:0]       oam_a_q;
    logic [10:0]      va_q;
    logic [7:0]       olb_a_q;
    logic [OLB_W-1:0] olb_d_q;
    logic             olb_we_q;

    s_objattr         attr;
    logic signed [9:0] dy;
    logic             hit;
    logic             last;
    logic [3:0]       j_nxt;
    logic             unused_attr;

    assign attr        = bus.OAM_D;
    // Row offset into the sprite; negative values (including y*2 beyond the row) miss.
    assign dy          = $signed({1'b0, row_q}) - $signed({2'b00, attr.y, 1'b0});
    assign hit         = ~dy[9] && (dy[8:4] == 5'd0);
    assign last        = (idx == 7'(OAM_COUNT - 1));
    assign j_nxt       = j_q + 4'd1;
    assign unused_attr = &{1'b0, attr.split, attr.link_x, attr.start_line, attr.link_y};

    assign bus.BUSY   = busy_q;
    assign bus.DONE   = done_q;
    assign bus.OAM_A  = oam_a_q;
    assign bus.VA     = va_q;
    assign bus.OLB_A  = olb_a_q;
    assign bus.OLB_D  = olb_d_q;
    assign bus.OLB_WE = olb_we_q;

    // Control FSM; every output is registered for the state being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            idx      <= 7'd0;
            j_q      <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            oam_a_q  <= 7'd0;
            va_q     <= 11'd0;
            olb_a_q  <= 8'd0;
            olb_d_q  <= '0;
            olb_we_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        state    <= CLEAR;
                        busy_q   <= 1'b1;
                        olb_we_q <= 1'b1;
                        olb_a_q  <= 8'd0;
                        olb_d_q  <= '0;
                    end
                end
                CLEAR: begin
                    if (olb_a_q == 8'(OLB_SIZE - 1)) begin
                        olb_we_q <= 1'b0;
                        idx      <= 7'd0;
                        oam_a_q  <= 7'd0;
                        state    <= OREAD;
                    end else begin
                        olb_a_q <= olb_a_q + 8'd1;
                    end
                end
                OREAD: state <= OEVAL;
                OEVAL: begin
                    if (hit) begin
                        va_q  <= {attr.pat, dy[3:1], 1'b0};
                        state <= FETCH0;
                    end else if (last) begin
                        done_q <= 1'b1;
                        state  <= FIN;
                    end else begin
                        idx     <= idx + 7'd1;
                        oam_a_q <= idx + 7'd1;
                        state   <= OREAD;
                    end
                end
                FETCH0: begin
                    va_q  <= {pat_q, sy_q[3:1], 1'b1};
                    state <= FETCH1;
                end
                FETCH1: begin
                    // First column comes straight from the word arriving now.
                    j_q      <= 4'd0;
                    olb_we_q <= pix_sel(bus.VD, w1_q, 4'd0, sy_q[0]);
                    olb_a_q  <= {x_q, 1'b0};
                    olb_d_q  <= {1'b1, color_q};
                    state    <= DRAW;
                end
                DRAW: begin
                    if (j_q == 4'(SPR_H - 1)) begin
                        olb_we_q <= 1'b0;
                        if (last) begin
                            done_q <= 1'b1;
                            state  <= FIN;
                        end else begin
                            idx     <= idx + 7'd1;
                            oam_a_q <= idx + 7'd1;
                            state   <= OREAD;
                        end
                    end else begin
                        j_q      <= j_nxt;
                        olb_we_q <= pix_sel(w0_q, w1_q, j_nxt, sy_q[0]);
                        olb_a_q  <= {x_q, 1'b0} + {4'd0, j_nxt};
                    end
                end
                FIN: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath captures: row, hit sprite attributes and its two pattern words.
    always_ff @(posedge CLK) begin
        if (state == IDLE && bus.START) begin
            row_q <= bus.ROW;
        end
        if (state == OEVAL && hit) begin
            sy_q    <= dy[3:0];
            pat_q   <= attr.pat;
            x_q     <= attr.x;
            color_q <= attr.color;
        end
        if (state == FETCH1) begin
            w0_q <= bus.VD;
        end
        if (state == DRAW && j_q == 4'd0) begin
            w1_q <= bus.VD;
        end
    end

endmodule

// File: tb/tb_epochtv1_olb_fill.sv
// Scoreboard bench for the OLB fill engine with behavioural OAM/VRAM/OLB memories.
module tb_epochtv1_olb_fill;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    epochtv1_olb_fill_if bus();

    epochtv1_olb_fill dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0] a;
        logic [4:0] d;
    } wr_t;

    logic [31:0] oam  [128];
    logic [15:0] vram [2048];
    logic [4:0]  olb  [256];

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [10:0] va_log[$];
    logic [10:0] va_prev = 11'd0;
    int          tests_run = 0;
    int          tests_failed = 0;
    int          wr_cnt = 0;
    bit          sb_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] x, input logic [6:0] y,
                                       input logic [6:0] pat, input logic [3:0] c);
        return {1'b0, pat, x, 1'b0, 4'b0000, c, y, 1'b0};
    endfunction

    // Synchronous-read OAM/VRAM and the OLB being written.
    always @(posedge CLK) begin
        bus.OAM_D <= oam[bus.OAM_A];
        bus.VD    <= vram[bus.VA];
        if (bus.OLB_WE) olb[bus.OLB_A] <= bus.OLB_D;
    end

    // Write monitor: every OLB write is popped against the expected sequence.
    always @(negedge CLK) begin
        if (bus.OLB_WE) begin
            wr_cnt <= wr_cnt + 1;
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    chk("wr_extra", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", 32'(bus.OLB_A), 32'(mon_e.a));
                    chk("wr_data", 32'(bus.OLB_D), 32'(mon_e.d));
                end
            end
        end
        if (bus.VA != va_prev) begin
            va_log.push_back(bus.VA);
            va_prev <= bus.VA;
        end
    end

    task automatic init_mem(input logic [15:0] vfill);
        for (int i = 0; i < 128; i++) oam[i] = mk(7'd0, 7'd127, 7'd0, 4'd0);
        for (int v = 0; v < 2048; v++) vram[v] = vfill;
    endtask

    // Reference fill: clear pass then every hitting sprite, in OAM order.
    task automatic model_fill(input int r);
        int dy, x, y, pat, col, sy, base, bitpos;
        logic [15:0] w0, w1, w;
        wr_t e;
        for (int a = 0; a < 256; a++) begin
            e.a = 8'(a); e.d = 5'd0; exp_q.push_back(e);
        end
        for (int i = 0; i < 128; i++) begin
            pat = int'(oam[i][30:24]);
            x   = int'(oam[i][23:17]);
            col = int'(oam[i][11:8]);
            y   = int'(oam[i][7:1]);
            dy  = r - 2 * y;
            if (dy >= 0 && dy <= 15) begin
                sy   = dy;
                base = pat * 16 + (sy / 2) * 2;
                w0   = vram[base];
                w1   = vram[base + 1];
                for (int j = 0; j < 16; j++) begin
                    w = (j < 8) ? w0 : w1;
                    bitpos = 15 - (((j & 4) != 0) ? 0 : 8) - ((sy % 2) * 4) - (j & 3);
                    if (w[bitpos]) begin
                        e.a = 8'((2 * x + j) % 256);
                        e.d = 5'(16 + col);
                        exp_q.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic run_fill(input int r, input int exp_done, input bit poke);
        int done_cyc;
        int extra;
        exp_q.delete();
        model_fill(r);
        va_log.delete();
        sb_en = 1'b1;
        @(negedge CLK);
        bus.START = 1'b1;
        bus.ROW   = 9'(r);
        @(posedge CLK); #1;
        bus.START = 1'b0;
        chk("busy_c1", 32'(bus.BUSY), 32'd1);
        done_cyc = -1;
        for (int m = 1; m <= 1500; m++) begin
            bus.START = (poke && m == 100) ? 1'b1 : 1'b0;
            @(posedge CLK); #1;
            if (bus.DONE) begin
                done_cyc = m + 1;
                break;
            end
        end
        bus.START = 1'b0;
        chk("done_cycle", 32'(done_cyc), 32'(exp_done));
        chk("busy_in_fin", 32'(bus.BUSY), 32'd1);
        extra = 0;
        repeat (20) begin
            @(posedge CLK); #1;
            if (bus.DONE) extra++;
        end
        chk("single_done", 32'(extra), 32'd0);
        chk("idle_busy", 32'(bus.BUSY), 32'd0);
        chk("sb_left", 32'(exp_q.size()), 32'd0);
        sb_en = 1'b0;
    endtask

    initial begin
        int wc;
        int dones;
        RST = 1'b1;
        bus.START = 1'b0;
        bus.ROW = 9'd0;
        init_mem(16'h0000);

        // Reset hold, then release.
        repeat (5) @(posedge CLK);
        #1;
        chk("rst_busy",  32'(bus.BUSY),   32'd0);
        chk("rst_done",  32'(bus.DONE),   32'd0);
        chk("rst_we",    32'(bus.OLB_WE), 32'd0);
        chk("rst_oam_a", 32'(bus.OAM_A),  32'd0);
        chk("rst_va",    32'(bus.VA),     32'd0);
        chk("rst_olb_a", 32'(bus.OLB_A),  32'd0);
        chk("rst_olb_d", 32'(bus.OLB_D),  32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("rel_busy", 32'(bus.BUSY),   32'd0);
        chk("rel_we",   32'(bus.OLB_WE), 32'd0);

        // No hits: clear only.
        wc = wr_cnt;
        run_fill(100, 513, 1'b0);
        chk("clear_writes", 32'(wr_cnt - wc), 32'd256);

        // Single hit, one opaque pixel.
        init_mem(16'h0000);
        oam[0] = mk(7'd10, 7'd20, 7'd3, 4'd5);
        vram[11'h034] = 16'h0008;
        vram[11'h035] = 16'h0000;
        wc = wr_cnt;
        run_fill(45, 531, 1'b0);
        chk("va_count", 32'(va_log.size()), 32'd2);
        chk("va0", 32'((va_log.size() > 0) ? va_log[0] : 11'h7FF), 32'h034);
        chk("va1", 32'((va_log.size() > 1) ? va_log[1] : 11'h7FF), 32'h035);
        chk("one_pixel_writes", 32'(wr_cnt - wc), 32'd257);
        chk("olb20", 32'(olb[20]), 32'h15);
        chk("olb21", 32'(olb[21]), 32'h00);

        // Overlap: higher index wins.
        init_mem(16'hFFFF);
        oam[0] = mk(7'd10, 7'd20, 7'd3, 4'd2);
        oam[1] = mk(7'd10, 7'd20, 7'd3, 4'd9);
        run_fill(45, 549, 1'b0);
        for (int a = 20; a < 36; a++) chk("overlap", 32'(olb[a]), 32'h19);
        chk("overlap_lo", 32'(olb[19]), 32'h00);
        chk("overlap_hi", 32'(olb[36]), 32'h00);

        // X wrap within the 8-bit OLB address.
        init_mem(16'hFFFF);
        oam[0] = mk(7'd125, 7'd20, 7'd1, 4'd7);
        run_fill(45, 531, 1'b0);
        chk("wrap250", 32'(olb[250]), 32'h17);
        chk("wrap255", 32'(olb[255]), 32'h17);
        chk("wrap0",   32'(olb[0]),   32'h17);
        chk("wrap9",   32'(olb[9]),   32'h17);
        chk("wrap10",  32'(olb[10]),  32'h00);
        chk("wrap249", 32'(olb[249]), 32'h00);

        // Vertical bounds with random patterns; START poked while busy.
        init_mem(16'h0000);
        for (int v = 0; v < 2048; v++) vram[v] = 16'($urandom);
        oam[0] = mk(7'd3, 7'd20, 7'd2, 4'd4);
        run_fill(40, 531, 1'b1);
        run_fill(55, 531, 1'b0);
        run_fill(39, 513, 1'b0);
        run_fill(56, 513, 1'b0);

        // Reset in the middle of DRAW.
        init_mem(16'hFFFF);
        oam[0] = mk(7'd10, 7'd20, 7'd3, 4'd5);
        @(negedge CLK);
        bus.START = 1'b1;
        bus.ROW   = 9'd45;
        @(posedge CLK); #1;
        bus.START = 1'b0;
        repeat (264) @(posedge CLK);
        #1;
        chk("draw_we_pre", 32'(bus.OLB_WE), 32'd1);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("mid_we",    32'(bus.OLB_WE), 32'd0);
        chk("mid_busy",  32'(bus.BUSY),   32'd0);
        chk("mid_done",  32'(bus.DONE),   32'd0);
        chk("mid_va",    32'(bus.VA),     32'd0);
        chk("mid_olb_a", 32'(bus.OLB_A),  32'd0);
        chk("mid_olb_d", 32'(bus.OLB_D),  32'd0);
        chk("mid_oam_a", 32'(bus.OAM_A),  32'd0);
        RST = 1'b0;
        wc = wr_cnt;
        dones = 0;
        repeat (600) begin
            @(posedge CLK); #1;
            if (bus.DONE) dones++;
        end
        chk("mid_no_done",   32'(dones),         32'd0);
        chk("mid_no_writes", 32'(wr_cnt - wc),   32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
